btn_count_ctrl: RTL and testbench
=================================

# btn_count_ctrl

Pushbutton-driven 8-bit up/down counter that produces the hex value shown on the four-digit seven-segment display. It sits directly upstream of the hex decode / display-multiplex stage, taking the place of raw switches as the source of the 8-bit value. It synchronizes and debounces two mechanical buttons, converts each debounced press into a single-cycle event, and updates a wrap-around counter.

## Interface
- N, 19: tick-divider width; debounce sample tick every 2^N clocks (about 10.5 ms at 50 MHz).
- DB_CNT, 3: consecutive ticks with a stable level required to accept a level change (1..7).
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- btn_up  input  1  raw increment button, active-high, asynchronous to clk
- btn_dn  input  1  raw decrement button, active-high, asynchronous to clk
- clr  input  1  synchronous clear of count, already clean, active-high
- count  output  8  current counter value; feeds the hex decoders
- up_tick  output  1  one-cycle pulse per accepted up press
- dn_tick  output  1  one-cycle pulse per accepted down press
- db_up, db_dn  output  1  debounced button levels, for LEDs and debug

One clock. Reset is asynchronous and active-low.

## Operation
- Synchronizer: each button passes through a 2-FF synchronizer, all FFs reset to 0.
- Tick: a free-running N-bit counter resets to 0 and increments every clock. tick = (divider == all-ones), so the first tick is at cycle 2^N−1 after reset release. One divider is shared by both debouncers.
- Debouncer FSM, one per button, with a 3-bit confirm counter:
  - ZERO: level 0. If sync=1, go to WAIT1 and load confirm=DB_CNT.
  - WAIT1: level 0. If sync=0, go to ZERO. Else on a tick, decrement confirm; on a tick with confirm==1, go to ONE.
  - ONE: level 1. If sync=0, go to WAIT0 and load confirm=DB_CNT.
  - WAIT0: level 1. If sync=1, go to ONE. Else on a tick with confirm==1, go to ZERO; on other ticks, decrement.
  - A bounce resets qualification. Acceptance therefore needs DB_CNT ticks of stable input, with the first partial tick interval included.
- Edge detect: up_tick/dn_tick are registered as (level & ~level_d). Each is high for exactly one cycle per ZERO→ONE transition. Release produces no pulse.
- Counter priority: clr > (up_tick & dn_tick: hold) > up_tick: +1 > dn_tick: −1 > hold.
- Arithmetic is modulo 256: 255+1 → 0 and 0−1 → 255.

## Timing
- Reset values: count=0, up_tick=0, dn_tick=0, db_up=0, db_dn=0; FSMs in ZERO, divider 0, confirm 0.
- Synchronizer latency is 2 cycles from a raw edge to the sync signal.
- db level changes on the clock edge that samples the accepting tick.
- The tick pulse is asserted in the cycle after the db level rises.
- count changes at the end of the tick cycle, so it is visible 1 cycle after the pulse.
- Held button: exactly one pulse; no auto-repeat.
- Simultaneous up and down pulses: count unchanged, both pulses still visible.
- clr coincident with a pulse: count=0 and the pulse is ignored.
- reset_n asserted mid-qualification: immediate return to the reset state. A button still held after release re-qualifies from ZERO and generates a fresh pulse.

## Structure
- Shared package btn_count_pkg: debouncer state enum (DB_ZERO, DB_WAIT1, DB_ONE, DB_WAIT0) and COUNT_W=8.
- Sub-module btn_debounce, one instance per button. It contains the synchronizer, FSM, confirm counter and edge register, with tick as an input.
- The top level holds the tick divider and the count register.

## Test plan
Bench settings: N=4, DB_CNT=3, tick every 16 cycles.
- Reset: hold reset_n=0, then release. Required: count=0x00, no pulses, first tick at cycle 15.
- Clean press: btn_up=1 for 100 cycles. Required: db_up rises after the 3rd tick, exactly one up_tick, count=0x01. Release gives no pulse and db_up falls 3 ticks later.
- Bounce: btn_up toggles every 5 cycles for 60 cycles, then holds 1. Required: no pulse during the toggling, one pulse after stable qualification, count +1 only.
- Wrap: 255 up presses from 0 gives count=0xFF; one more gives 0x00. Then one dn press gives 0xFF.
- Simultaneous: both buttons pressed on the same cycle with count=0x10. Required: up_tick and dn_tick pulse together, count stays 0x10. Then clr=1 for 1 cycle gives count=0x00.
- Reset mid-qualification: assert reset_n=0 while in WAIT1 with btn_up held. Required: outputs at reset values immediately. After release, one up_tick once 3 new ticks have elapsed, and count=0x01.

Source files
------------

// File: rtl/btn_count_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_count_pkg                                                        |
// | Shared types and widths for the pushbutton counter slice.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package btn_count_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    DB_ZERO  = 2'd0,
    DB_WAIT1 = 2'd1,
    DB_ONE   = 2'd2,
    DB_WAIT0 = 2'd3
  } db_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce                                                         |
// | 2-FF synchronizer, tick-qualified debounce FSM and rising-edge pulse.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce
  import btn_count_pkg::*;
#(
  parameter int DB_CNT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic tick,
  output logic level,
  output logic pulse
);

  localparam logic [2:0] CONFIRM_LOAD = 3'(DB_CNT);

  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [2:0] confirm_q, confirm_d;
  logic      level_prev_q;
  logic      pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Any disagreement with the target level drops back and discards progress.
  always_comb begin
    state_d   = state_q;
    confirm_d = confirm_q;
    case (state_q)
      DB_ZERO: begin
        if (sync2_q) begin
          state_d   = DB_WAIT1;
          confirm_d = CONFIRM_LOAD;
        end
      end
      DB_WAIT1: begin
        if (!sync2_q) begin
          state_d = DB_ZERO;
        end else if (tick) begin
          if (confirm_q == 3'd1) state_d = DB_ONE;
          confirm_d = confirm_q - 3'd1;
        end
      end
      DB_ONE: begin
        if (!sync2_q) begin
          state_d   = DB_WAIT0;
          confirm_d = CONFIRM_LOAD;
        end
      end
      DB_WAIT0: begin
        if (sync2_q) begin
          state_d = DB_ONE;
        end else if (tick) begin
          if (confirm_q == 3'd1) state_d = DB_ZERO;
          confirm_d = confirm_q - 3'd1;
        end
      end
      default: state_d = DB_ZERO;
    endcase
  end

  assign level = (state_q == DB_ONE) || (state_q == DB_WAIT0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DB_ZERO;
      confirm_q    <= 3'd0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      confirm_q    <= confirm_d;
      level_prev_q <= level;
      pulse_q      <= level & ~level_prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/btn_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_count_ctrl                                                       |
// | Debounced up/down pushbuttons driving a wrap-around 8-bit counter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_count_ctrl
  import btn_count_pkg::*;
#(
  parameter int N      = 19,
  parameter int DB_CNT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_dn,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               up_tick,
  output logic               dn_tick,
  output logic               db_up,
  output logic               db_dn
);

  logic [N-1:0]       divider_q;
  logic               tick;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) divider_q <= '0;
    else          divider_q <= divider_q + 1'b1;
  end

  assign tick = &divider_q;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_up (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_up),
    .tick    (tick),
    .level   (db_up),
    .pulse   (up_tick)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_dn (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (btn_dn),
    .tick    (tick),
    .level   (db_dn),
    .pulse   (dn_tick)
  );

  // Opposing presses in the same cycle cancel; clear overrides everything.
  always_comb begin
    count_d = count_q;
    if (clr)                      count_d = '0;
    else if (up_tick && dn_tick)  count_d = count_q;
    else if (up_tick)             count_d = count_q + 1'b1;
    else if (dn_tick)             count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_btn_count_ctrl                                                    |
// | Directed bench: N=4, DB_CNT=3, so the debounce tick falls every 16.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_btn_count_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_up, btn_dn, clr;
  logic [7:0] count;
  logic       up_tick, dn_tick, db_up, db_dn;

  int vecs   = 0;
  int errs   = 0;
  int cyc    = 0;
  int up_cnt = 0;

  btn_count_ctrl #(.N(4), .DB_CNT(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .clr     (clr),
    .count   (count),
    .up_tick (up_tick),
    .dn_tick (dn_tick),
    .db_up   (db_up),
    .db_dn   (db_dn)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (up_tick === 1'b1) up_cnt <= up_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // sel: 0 db_up high, 1 db_up low, 2 db_dn high, 3 db_dn low, 4 up_tick
  task automatic wait_for(input int sel, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = (db_up === 1'b1);
        1:       hit = (db_up === 1'b0);
        2:       hit = (db_dn === 1'b1);
        3:       hit = (db_dn === 1'b0);
        default: hit = (up_tick === 1'b1);
      endcase
    end
    chk(tag, {7'd0, hit}, 8'd1);
  endtask

  task automatic press(input logic u);
    btn_up = u;
    btn_dn = ~u;
    wait_for(u ? 0 : 2, "press_rise");
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_for(u ? 1 : 3, "press_fall");
  endtask

  initial begin
    reset_n = 1'b0;
    btn_up  = 1'b0;
    btn_dn  = 1'b0;
    clr     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 8'h00);
    chk("rst_pulses", {6'd0, up_tick, dn_tick}, 8'h00);
    chk("rst_levels", {6'd0, db_up, db_dn}, 8'h00);
    reset_n = 1'b1;

    // Clean press: WAIT1 entered at edge 5, ticks at 16/32/48.
    to_cycle(1);  chk("post_rst_count", count, 8'h00);
    to_cycle(2);  btn_up = 1'b1;
    to_cycle(47); chk("clean_db_before", {7'd0, db_up}, 8'd0);
    to_cycle(48); chk("clean_db_rise", {7'd0, db_up}, 8'd1);
                  chk("clean_no_early_pulse", {7'd0, up_tick}, 8'd0);
    to_cycle(49); chk("clean_up_tick", {6'd0, up_tick, dn_tick}, 8'h02);
                  chk("clean_count_lag", count, 8'h00);
    to_cycle(50); chk("clean_count", count, 8'h01);
                  chk("clean_pulse_width", {7'd0, up_tick}, 8'd0);
    to_cycle(102); chk("clean_one_pulse", up_cnt[7:0], 8'd1);
    btn_up = 1'b0;
    to_cycle(143); chk("release_db_hold", {7'd0, db_up}, 8'd1);
    to_cycle(144); chk("release_db_fall", {7'd0, db_up}, 8'd0);
    to_cycle(150); chk("release_no_pulse", up_cnt[7:0], 8'd1);
                   chk("release_count", count, 8'h01);

    // Bounce: toggle every 5 cycles, then hold from cycle 210.
    for (int j = 0; j < 12; j++) begin
      to_cycle(150 + 5 * j);
      btn_up = (j % 2 == 0);
    end
    to_cycle(210); btn_up = 1'b1;
    to_cycle(255); chk("bounce_db_low", {7'd0, db_up}, 8'd0);
                   chk("bounce_no_pulse", up_cnt[7:0], 8'd1);
    to_cycle(256); chk("bounce_db_rise", {7'd0, db_up}, 8'd1);
    to_cycle(257); chk("bounce_up_tick", {7'd0, up_tick}, 8'd1);
    to_cycle(258); chk("bounce_count", count, 8'h02);
    to_cycle(260); chk("bounce_one_pulse", up_cnt[7:0], 8'd2);
    btn_up = 1'b0;
    to_cycle(304); chk("bounce_release", {7'd0, db_up}, 8'd0);

    to_cycle(310); clr = 1'b1;
    to_cycle(311); clr = 1'b0;
    chk("clr_count", count, 8'h00);

    for (int i = 0; i < 255; i++) press(1'b1);
    chk("wrap_ff", count, 8'hFF);
    press(1'b1);
    chk("wrap_00", count, 8'h00);
    press(1'b0);
    chk("wrap_dn_ff", count, 8'hFF);

    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_from_ff", count, 8'h00);
    for (int i = 0; i < 16; i++) press(1'b1);
    chk("preload_10", count, 8'h10);

    btn_up = 1'b1;
    btn_dn = 1'b1;
    wait_for(4, "simul_wait");
    chk("simul_dn_tick", {7'd0, dn_tick}, 8'd1);
    @(negedge clk);
    chk("simul_count_hold", count, 8'h10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_for(1, "simul_fall");
    chk("simul_db_dn_fall", {7'd0, db_dn}, 8'd0);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("simul_clr", count, 8'h00);

    press(1'b1);
    chk("pre_clr_pulse", count, 8'h01);
    btn_up = 1'b1;
    wait_for(4, "clr_pulse_wait");
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_beats_pulse", count, 8'h00);
    btn_up = 1'b0;
    wait_for(1, "clr_pulse_fall");

    // Reset while qualifying a held button, then re-qualify from ZERO.
    press(1'b1);
    chk("pre_rst_count", count, 8'h01);
    btn_up = 1'b1;
    repeat (10) @(negedge clk);
    chk("midq_db_low", {7'd0, db_up}, 8'd0);
    reset_n = 1'b0;
    #1;
    chk("midq_rst_count", count, 8'h00);
    chk("midq_rst_outs", {5'd0, up_tick, dn_tick, db_dn}, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    to_cycle(47); chk("requal_db_before", {7'd0, db_up}, 8'd0);
    to_cycle(48); chk("requal_db_rise", {7'd0, db_up}, 8'd1);
    to_cycle(49); chk("requal_up_tick", {7'd0, up_tick}, 8'd1);
                  chk("requal_count_lag", count, 8'h00);
    to_cycle(50); chk("requal_count", count, 8'h01);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
